// File: rtl/mem_image_loader_pkg.sv
// Shared types and constants for the image loader controller.
package mem_image_loader_pkg;

  localparam int unsigned LANES      = 8;
  localparam int unsigned WORD_BYTES = 8;

  typedef enum logic [2:0] {
    StLoad,
    StWrite,
    StPad,
    StRun,
    StPass,
    StFail
  } state_e;

  // RAM word index of the first image byte.
  function automatic logic [31:0] base_word_idx(input logic [31:0] mem_base,
                                                input logic [31:0] load_base);
    return (load_base - mem_base) >> 3;
  endfunction

endpackage

// File: rtl/mem_image_loader_ctrl_packer.sv
// Packs a little-endian byte stream into 64-bit words, one lane per accepted byte.
module byte_word_packer
  import mem_image_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic [63:0] word_data,
  output logic        word_full,
  output logic        word_last
);

  logic [2:0]  lane_q, lane_d;
  logic [63:0] data_q, data_d;
  logic        last_q, last_d;

  always_comb begin
    lane_d = lane_q;
    data_d = data_q;
    last_d = last_q;
    if (clear) begin
      lane_d = '0;
      data_d = '0;
      last_d = 1'b0;
    end else if (byte_valid) begin
      data_d[{lane_q, 3'b000} +: 8] = byte_data;
      lane_d = lane_q + 3'd1;
      last_d = last_q | byte_last;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  // Asserted while the byte being accepted fills the final lane.
  assign word_full = byte_valid && (lane_q == 3'(LANES - 1));
  assign word_data = data_q;
  assign word_last = last_q;

endmodule

// File: rtl/mem_image_loader_ctrl.sv
// Streams an image into RAM as 64-bit words, holds the core in reset until the load
// completes, then runs the pass/timeout watchdog.
module mem_image_loader_ctrl
  import mem_image_loader_pkg::*;
#(
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [31:0] LOAD_BASE  = 32'h8020_0000,
  parameter logic [31:0] LOAD_BYTES = 32'h0100_0000,
  parameter int unsigned WADDR_W    = 24,
  parameter int unsigned CYC_W      = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CYC_W-1:0]   max_cycles,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [WADDR_W-1:0] wr_addr,
  output logic [63:0]        wr_data,
  output logic [7:0]         wr_strb,
  output logic               core_reset,
  input  logic               success,
  output logic               done,
  output logic               failed,
  output logic               timeout,
  output logic               overflow,
  output logic [CYC_W-1:0]   cycle_count,
  output logic [WADDR_W-1:0] load_words
);

  localparam logic [WADDR_W-1:0] BaseIdx  = WADDR_W'(base_word_idx(MEM_BASE, LOAD_BASE));
  localparam logic [WADDR_W-1:0] CapWords = WADDR_W'(LOAD_BYTES / WORD_BYTES);

  state_e             state_q, state_d;
  logic [WADDR_W-1:0] word_idx_q, word_idx_d;
  logic [CYC_W-1:0]   cycle_q, cycle_d;
  logic               done_q, done_d, failed_q, failed_d;
  logic               timeout_q, timeout_d, overflow_q, overflow_d;
  logic               active_q;
  logic               at_cap, byte_acc, pack_clear;
  logic [63:0]        pack_data;
  logic               pack_full, pack_last;

  byte_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_valid (byte_acc),
    .byte_data  (in_data),
    .byte_last  (in_last),
    .word_data  (pack_data),
    .word_full  (pack_full),
    .word_last  (pack_last)
  );

  assign at_cap   = (word_idx_q == CapWords);
  // active_q keeps in_ready low for the cycle in which reset is released.
  assign in_ready = active_q && (state_q == StLoad) && !at_cap;
  assign byte_acc = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    cycle_d    = cycle_q;
    done_d     = done_q;
    failed_d   = failed_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    pack_clear = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    unique case (state_q)
      StLoad: begin
        if (in_valid && active_q && at_cap) begin
          state_d    = StFail;
          overflow_d = 1'b1;
          failed_d   = 1'b1;
        end else if (byte_acc && (pack_full || in_last)) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        wr_valid = 1'b1;
        wr_data  = pack_data;
        if (wr_ready) begin
          word_idx_d = word_idx_q + WADDR_W'(1);
          pack_clear = 1'b1;
          if (!pack_last)         state_d = StLoad;
          else if (!word_idx_q[0]) state_d = StPad;  // count after increment is odd
          else                    state_d = StRun;
        end
      end
      StPad: begin
        wr_valid = 1'b1;
        if (wr_ready) begin
          word_idx_d = word_idx_q + WADDR_W'(1);
          state_d    = StRun;
        end
      end
      StRun: begin
        if ((max_cycles != '0) && (cycle_q == max_cycles)) begin
          state_d   = StFail;
          timeout_d = 1'b1;
          failed_d  = 1'b1;
        end else if (success) begin
          state_d = StPass;
          done_d  = 1'b1;
        end else if (cycle_q != '1) begin
          cycle_d = cycle_q + CYC_W'(1);
        end
      end
      StPass, StFail: ;
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StLoad;
      word_idx_q <= '0;
      cycle_q    <= '0;
      done_q     <= 1'b0;
      failed_q   <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      cycle_q    <= cycle_d;
      done_q     <= done_d;
      failed_q   <= failed_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      active_q   <= 1'b1;
    end
  end

  // The core is released in RUN and stays released unless the image overflowed.
  assign core_reset  = !((state_q == StRun) || (state_q == StPass) ||
                         ((state_q == StFail) && timeout_q));
  assign wr_addr     = BaseIdx + word_idx_q;
  assign wr_strb     = 8'hFF;
  assign done        = done_q;
  assign failed      = failed_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;
  assign cycle_count = cycle_q;
  assign load_words  = word_idx_q;

endmodule

// File: tb/tb_mem_image_loader_ctrl.sv
// Directed and randomized image loads checked against a byte-list reference model.
module tb_mem_image_loader_ctrl;

  localparam int unsigned     WADDR_W   = 24;
  localparam int unsigned     CYC_W     = 64;
  localparam logic [31:0]     LB        = 32'h40;
  localparam int              CAP_WORDS = 8;
  localparam logic [WADDR_W-1:0] BASE_IDX = 24'h04_0000;

  logic               clock, reset;
  logic [CYC_W-1:0]   max_cycles;
  logic               in_valid, in_ready, in_last;
  logic [7:0]         in_data;
  logic               wr_valid, wr_ready;
  logic [WADDR_W-1:0] wr_addr;
  logic [63:0]        wr_data;
  logic [7:0]         wr_strb;
  logic               core_reset, success, done, failed, timeout, overflow;
  logic [CYC_W-1:0]   cycle_count;
  logic [WADDR_W-1:0] load_words;

  mem_image_loader_ctrl #(.LOAD_BYTES(LB)) dut (
    .clock(clock), .reset(reset), .max_cycles(max_cycles),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .core_reset(core_reset), .success(success), .done(done),
    .failed(failed), .timeout(timeout), .overflow(overflow),
    .cycle_count(cycle_count), .load_words(load_words)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [63:0]        data;
    logic [7:0]         strb;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] img[$];
  int         cyc = 0;
  int         acc_cyc = 0;
  bit         overlap = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Writes are recorded half a cycle before the accepting edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (wr_valid && wr_ready) begin
        wq.push_back('{addr: wr_addr, data: wr_data, strb: wr_strb});
        acc_cyc = cyc;
      end
      if (in_ready && wr_valid) overlap = 1;
    end
  end

  function automatic logic [63:0] exp_word(input int k);
    logic [63:0] w = '0;
    for (int j = 0; j < 8; j++)
      if (8 * k + j < img.size()) w = w | (64'(img[8 * k + j]) << (8 * j));
    return w;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0; wr_ready = 1'b0; success = 1'b0;
    @(posedge clock); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_status", {done, failed, timeout, overflow}, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_load_words", load_words, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("rst_release_in_ready", in_ready, 1);
  endtask

  // mode 0: wr_ready tied high, 1: random, 2: first write stalled five cycles.
  task automatic load_image(input bit last_flag, input int mode, input bit expect_ovf);
    int i = 0;
    int budget = 0;
    int stall = 0;
    int fall_cyc;
    int nw, total;
    bit snap = 0;
    bit acc;
    logic [WADDR_W-1:0] s_addr;
    logic [63:0] s_data;
    wq.delete();
    overlap = 0;
    while (core_reset && !failed && budget < 3000) begin
      in_valid = (i < img.size());
      in_data  = in_valid ? img[i] : 8'h00;
      in_last  = last_flag && (i == img.size() - 1);
      if (mode == 0) wr_ready = 1'b1;
      else if (mode == 1) wr_ready = 1'($urandom_range(0, 1));
      else if (wr_valid && stall < 5) begin
        if (!snap) begin
          s_addr = wr_addr; s_data = wr_data; snap = 1;
        end else begin
          check("stall_addr", wr_addr, s_addr);
          check("stall_data", wr_data, s_data);
        end
        check("stall_in_ready", in_ready, 0);
        wr_ready = 1'b0;
        stall++;
      end else begin
        if (wr_valid && stall == 5) begin
          check("stall_hold_addr", wr_addr, s_addr);
          check("stall_hold_data", wr_data, s_data);
          stall = 6;
        end
        wr_ready = 1'b1;
      end
      acc = in_valid && in_ready;
      @(posedge clock); #1;
      if (acc) i++;
      budget++;
    end
    fall_cyc = cyc;
    in_valid = 1'b0; in_last = 1'b0; wr_ready = 1'b0;
    check("load_terminates", budget < 3000, 1);
    nw = expect_ovf ? CAP_WORDS : (img.size() + 7) / 8;
    total = nw + ((!expect_ovf && (nw % 2 == 1)) ? 1 : 0);
    check("n_writes", wq.size(), total);
    for (int k = 0; k < total && k < wq.size(); k++) begin
      check("wr_addr", wq[k].addr, BASE_IDX + WADDR_W'(k));
      check("wr_data", wq[k].data, (k < nw) ? exp_word(k) : 64'h0);
      check("wr_strb", wq[k].strb, 8'hFF);
    end
    check("load_words", load_words, total);
    check("no_ready_valid_overlap", overlap, 0);
    if (expect_ovf) begin
      check("ovf_flags", {done, failed, timeout, overflow}, 4'b0101);
      check("ovf_core_reset", core_reset, 1);
      check("ovf_in_ready", in_ready, 0);
    end else begin
      check("core_reset_fall_cycle", fall_cyc, acc_cyc + 1);
      check("run_core_reset", core_reset, 0);
    end
  endtask

  // s is the 1-based RUN cycle on which success is raised (0 = never).
  task automatic run_core(input logic [63:0] maxc, input int s);
    int  k = 1;
    bit  exp_to;
    logic [63:0] exp_cnt;
    while (!done && !failed && k < 500) begin
      success = (k == s);
      @(posedge clock); #1;
      k++;
    end
    success = 1'b0;
    check("run_terminates", k < 500, 1);
    exp_to  = (maxc != 0) && (s == 0 || s > maxc);
    exp_cnt = exp_to ? maxc : 64'(s - 1);
    check("run_done", done, !exp_to);
    check("run_failed", failed, exp_to);
    check("run_timeout", timeout, exp_to);
    check("run_overflow", overflow, 0);
    check("run_cycle_count", cycle_count, exp_cnt);
    check("run_core_reset_low", core_reset, 0);
    repeat (4) begin
      success = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    success = 1'b0;
    check("hold_status", {done, failed, timeout}, {!exp_to, exp_to, exp_to});
    check("hold_cycle_count", cycle_count, exp_cnt);
  endtask

  initial begin
    int n, s;
    logic [63:0] m;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    wr_ready = 1'b0; success = 1'b0; max_cycles = '0;

    // Sixteen sequential bytes: two full words, no pad.
    do_reset();
    img.delete();
    for (int b = 0; b < 16; b++) img.push_back(8'(b));
    max_cycles = 64'd100;
    load_image(1, 0, 0);
    if (wq.size() >= 2) begin
      check("t1_word0", wq[0].data, 64'h0706050403020100);
      check("t1_word1", wq[1].data, 64'h0F0E0D0C0B0A0908);
      check("t1_addr1", wq[1].addr, 24'h040001);
    end
    run_core(64'd100, 5);

    // Partial word plus pad, then timeout.
    do_reset();
    img = '{8'hAA, 8'hBB, 8'hCC};
    max_cycles = 64'd10;
    load_image(1, 0, 0);
    if (wq.size() >= 2) begin
      check("t2_word0", wq[0].data, 64'h0000000000CCBBAA);
      check("t2_pad", wq[1].data, 64'h0);
    end
    run_core(64'd10, 0);

    // Stalled first write, then timeout/success tie.
    do_reset();
    img.delete();
    for (int b = 0; b < 9; b++) img.push_back(8'($urandom));
    max_cycles = 64'd4;
    load_image(1, 2, 0);
    run_core(64'd4, 5);

    // Reset on the third byte, then a fresh image from word 0.
    do_reset();
    in_valid = 1'b1; in_data = 8'h01;
    @(posedge clock); #1;
    in_data = 8'h02;
    @(posedge clock); #1;
    in_data = 8'h03;
    do_reset();
    img = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    max_cycles = 64'd0;
    load_image(1, 1, 0);
    if (wq.size() >= 1) check("t6_word0", wq[0].data, 64'h1817161514131211);
    run_core(64'd0, 7);

    // Image exactly at capacity.
    do_reset();
    img.delete();
    for (int b = 0; b < 64; b++) img.push_back(8'($urandom));
    max_cycles = 64'd20;
    load_image(1, 1, 0);
    run_core(64'd20, 0);

    // Random images and watchdog settings.
    repeat (5) begin
      do_reset();
      img.delete();
      n = $urandom_range(1, 64);
      for (int b = 0; b < n; b++) img.push_back(8'($urandom));
      m = 64'($urandom_range(0, 30));
      s = (m == 0) ? $urandom_range(1, 40) : $urandom_range(0, 40);
      max_cycles = m;
      load_image(1, 1, 0);
      run_core(m, s);
    end

    // One byte beyond capacity.
    do_reset();
    img.delete();
    for (int b = 0; b < 65; b++) img.push_back(8'($urandom));
    max_cycles = 64'd5;
    load_image(0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
